// File: rtl/fast_circle_fetch.sv
// Read sequencer for the image RAM: fetches the centre pixel and the 16-pixel radius-3
// Bresenham ring around a FAST candidate and streams them out tagged with their ring index.
module fast_circle_fetch #(
  parameter int X_MAX       = 200,
  parameter int Y_MAX       = 200,
  parameter int PIXEL_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [$clog2(X_MAX):0]     cx,
  input  logic [$clog2(Y_MAX):0]     cy,
  output logic                       busy,
  output logic                       done,
  output logic                       reject,
  output logic [$clog2(X_MAX):0]     ram_x_addr,
  output logic [$clog2(Y_MAX):0]     ram_y_addr,
  output logic                       ram_ren,
  input  logic [PIXEL_DEPTH-1:0]     ram_rdat,
  output logic                       pix_valid,
  output logic [4:0]                 pix_idx,
  output logic [PIXEL_DEPTH-1:0]     pix_data
);
  localparam int XW = $clog2(X_MAX) + 1;
  localparam int YW = $clog2(Y_MAX) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_REJ} state_t;

  // Clockwise ring offsets, y grows downward; k=0 is the centre itself.
  function automatic logic signed [3:0] off_dx(input logic [4:0] k);
    case (k)
      5'd2, 5'd8:                  off_dx = 4'sd1;
      5'd3, 5'd7:                  off_dx = 4'sd2;
      5'd4, 5'd5, 5'd6:            off_dx = 4'sd3;
      5'd10, 5'd16:                off_dx = -4'sd1;
      5'd11, 5'd15:                off_dx = -4'sd2;
      5'd12, 5'd13, 5'd14:         off_dx = -4'sd3;
      default:                     off_dx = 4'sd0;
    endcase
  endfunction

  function automatic logic signed [3:0] off_dy(input logic [4:0] k);
    case (k)
      5'd6, 5'd12:                 off_dy = 4'sd1;
      5'd7, 5'd11:                 off_dy = 4'sd2;
      5'd8, 5'd9, 5'd10:           off_dy = 4'sd3;
      5'd4, 5'd14:                 off_dy = -4'sd1;
      5'd3, 5'd15:                 off_dy = -4'sd2;
      5'd1, 5'd2, 5'd16:           off_dy = -4'sd3;
      default:                     off_dy = 4'sd0;
    endcase
  endfunction

  state_t                 state_q, state_d;
  logic [4:0]             k_q, k_d;
  logic [4:0]             ren_idx_q, ren_idx_d;
  logic [XW-1:0]          cx_q, cx_d;
  logic [YW-1:0]          cy_q, cy_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   reject_q, reject_d;
  logic                   ram_ren_q, ram_ren_d;
  logic [XW-1:0]          ram_x_addr_q, ram_x_addr_d;
  logic [YW-1:0]          ram_y_addr_q, ram_y_addr_d;
  logic                   pix_valid_q, pix_valid_d;
  logic [4:0]             pix_idx_q, pix_idx_d;
  logic [PIXEL_DEPTH-1:0] pix_data_q, pix_data_d;

  logic signed [3:0]      dx_s, dy_s;
  logic                   in_bounds_s;

  assign dx_s = off_dx(k_q);
  assign dy_s = off_dy(k_q);
  assign in_bounds_s = (cx >= XW'(3)) && (cx <= XW'(X_MAX - 4)) &&
                       (cy >= YW'(3)) && (cy <= YW'(Y_MAX - 4));

  // Next-state and next-output logic for the fetch sequencer and its return path.
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    ren_idx_d    = ren_idx_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    reject_d     = 1'b0;
    ram_ren_d    = 1'b0;
    ram_x_addr_d = ram_x_addr_q;
    ram_y_addr_d = ram_y_addr_q;

    // The RAM answers the read issued last cycle; tag it with that read's index.
    pix_valid_d = ram_ren_q;
    if (ram_ren_q) begin
      pix_idx_d  = ren_idx_q;
      pix_data_d = ram_rdat;
    end else begin
      pix_idx_d  = pix_idx_q;
      pix_data_d = pix_data_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cx_d = cx;
          cy_d = cy;
          if (in_bounds_s) begin
            state_d      = S_ISSUE;
            busy_d       = 1'b1;
            ram_ren_d    = 1'b1;
            ram_x_addr_d = cx;
            ram_y_addr_d = cy;
            ren_idx_d    = 5'd0;
            k_d          = 5'd1;
          end else begin
            state_d  = S_REJ;
            done_d   = 1'b1;
            reject_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (k_q <= 5'd16) begin
          ram_ren_d    = 1'b1;
          ram_x_addr_d = cx_q + {{(XW-4){dx_s[3]}}, dx_s};
          ram_y_addr_d = cy_q + {{(YW-4){dy_s[3]}}, dy_s};
          ren_idx_d    = k_q;
          k_d          = k_q + 5'd1;
        end else begin
          state_d = S_DRAIN;
          done_d  = 1'b1;
          k_d     = 5'd0;
        end
      end
      S_DRAIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      S_REJ: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        k_d     = 5'd0;
      end
    endcase
  end

  // State and output registers; reset abandons any fetch and drops in-flight reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      k_q          <= 5'd0;
      ren_idx_q    <= 5'd0;
      cx_q         <= '0;
      cy_q         <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      reject_q     <= 1'b0;
      ram_ren_q    <= 1'b0;
      ram_x_addr_q <= '0;
      ram_y_addr_q <= '0;
      pix_valid_q  <= 1'b0;
      pix_idx_q    <= 5'd0;
      pix_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      ren_idx_q    <= ren_idx_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      reject_q     <= reject_d;
      ram_ren_q    <= ram_ren_d;
      ram_x_addr_q <= ram_x_addr_d;
      ram_y_addr_q <= ram_y_addr_d;
      pix_valid_q  <= pix_valid_d;
      pix_idx_q    <= pix_idx_d;
      pix_data_q   <= pix_data_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign reject     = reject_q;
  assign ram_ren    = ram_ren_q;
  assign ram_x_addr = ram_x_addr_q;
  assign ram_y_addr = ram_y_addr_q;
  assign pix_valid  = pix_valid_q;
  assign pix_idx    = pix_idx_q;
  assign pix_data   = pix_data_q;

endmodule

// File: tb/tb_fast_circle_fetch.sv
// Self-checking bench for fast_circle_fetch: a timeline model predicts every output each
// cycle from the accepted start, and directed tests pin the model with literal pixel values.
module tb_fast_circle_fetch;
  localparam int XM = 200;
  localparam int YM = 200;
  localparam int XW = $clog2(XM) + 1;
  localparam int YW = $clog2(YM) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [XW-1:0] cx;
  logic [YW-1:0] cy;
  logic          busy, done, reject, ram_ren, pix_valid;
  logic [XW-1:0] ram_x_addr;
  logic [YW-1:0] ram_y_addr;
  logic [7:0]    ram_rdat;
  logic [4:0]    pix_idx;
  logic [7:0]    pix_data;

  fast_circle_fetch #(.X_MAX(XM), .Y_MAX(YM), .PIXEL_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .cx(cx), .cy(cy),
    .busy(busy), .done(done), .reject(reject),
    .ram_x_addr(ram_x_addr), .ram_y_addr(ram_y_addr), .ram_ren(ram_ren),
    .ram_rdat(ram_rdat), .pix_valid(pix_valid), .pix_idx(pix_idx), .pix_data(pix_data)
  );

  always #5 clk = ~clk;

  // Image RAM preloaded with p(x,y) = (x + 2y) mod 256, read at the presented address.
  always_comb ram_rdat = 8'((int'(ram_x_addr) + 2 * int'(ram_y_addr)) % 256);

  int dxs [17] = '{0, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
  int dys [17] = '{0, -3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

  int n_checks = 0;
  int n_err    = 0;

  int edge_cnt = 0;
  bit f_on = 1'b0;
  bit f_rej = 1'b0;
  int f_t0 = 0, f_cx = 0, f_cy = 0;

  int pv_cnt = 0, dn_cnt = 0, rj_cnt = 0, rn_cnt = 0;
  int captured [17];

  function automatic int pix(input int x, input int y);
    return (x + 2 * y) % 256;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Model: decides which starts are accepted and whether they are rejected.
  initial begin
    forever begin
      @(posedge clk);
      edge_cnt++;
      if (rst) begin
        f_on = 1'b0;
      end else if (start && (!f_on || edge_cnt >= f_t0 + (f_rej ? 2 : 19))) begin
        f_on  = 1'b1;
        f_t0  = edge_cnt;
        f_cx  = int'(cx);
        f_cy  = int'(cy);
        f_rej = !(int'(cx) >= 3 && int'(cx) <= XM - 4 && int'(cy) >= 3 && int'(cy) <= YM - 4);
      end
    end
  end

  // Compare: every cycle, outputs against the timeline implied by the last accepted start.
  initial begin
    int m, e_busy, e_done, e_rej, e_ren, e_valid, e_idx, e_data;
    int last_x, last_y;
    last_x = 0;
    last_y = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_x = 0;
        last_y = 0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_reject", int'(reject), 0);
        chk("rst_ren", int'(ram_ren), 0);
        chk("rst_xaddr", int'(ram_x_addr), 0);
        chk("rst_yaddr", int'(ram_y_addr), 0);
        chk("rst_valid", int'(pix_valid), 0);
        chk("rst_idx", int'(pix_idx), 0);
        chk("rst_data", int'(pix_data), 0);
      end else begin
        e_busy = 0; e_done = 0; e_rej = 0; e_ren = 0; e_valid = 0; e_idx = 0; e_data = 0;
        if (f_on) begin
          m = edge_cnt - f_t0 + 1;
          if (f_rej) begin
            e_done = (m == 1) ? 1 : 0;
            e_rej  = e_done;
          end else begin
            e_busy = (m >= 1 && m <= 18) ? 1 : 0;
            e_done = (m == 18) ? 1 : 0;
            if (m >= 1 && m <= 17) begin
              e_ren  = 1;
              last_x = f_cx + dxs[m-1];
              last_y = f_cy + dys[m-1];
            end
            if (m >= 2 && m <= 18) begin
              e_valid = 1;
              e_idx   = m - 2;
              e_data  = pix(f_cx + dxs[m-2], f_cy + dys[m-2]);
            end
          end
        end
        chk("busy", int'(busy), e_busy);
        chk("done", int'(done), e_done);
        chk("reject", int'(reject), e_rej);
        chk("ram_ren", int'(ram_ren), e_ren);
        chk("ram_x_addr", int'(ram_x_addr), last_x);
        chk("ram_y_addr", int'(ram_y_addr), last_y);
        chk("pix_valid", int'(pix_valid), e_valid);
        if (e_valid == 1) begin
          chk("pix_idx", int'(pix_idx), e_idx);
          chk("pix_data", int'(pix_data), e_data);
        end
        if (pix_valid && pix_idx < 5'd17) captured[pix_idx] = int'(pix_data);
        if (pix_valid) pv_cnt++;
        if (done) dn_cnt++;
        if (reject) rj_cnt++;
        if (ram_ren) rn_cnt++;
      end
    end
  end

  int pv0, dn0, rj0, rn0;

  task automatic snap();
    pv0 = pv_cnt; dn0 = dn_cnt; rj0 = rj_cnt; rn0 = rn_cnt;
  endtask

  task automatic pulse(input int x, input int y);
    cx = XW'(x);
    cy = YW'(y);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  int rej_x [3] = '{2, 197, 100};
  int rej_y [3] = '{50, 100, 197};

  // Directed stimulus; each call to pulse is issued at a falling edge.
  initial begin
    rst = 1'b1; start = 1'b0; cx = '0; cy = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_pix_data", int'(pix_data), 0);
    chk("reset_xaddr", int'(ram_x_addr), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    snap();
    pulse(100, 100);
    repeat (20) @(negedge clk);
    chk("c100_idx0", captured[0], 44);
    chk("c100_idx1", captured[1], 38);
    chk("c100_idx5", captured[5], 47);
    chk("c100_idx9", captured[9], 50);
    chk("c100_idx13", captured[13], 41);
    chk("c100_npix", pv_cnt - pv0, 17);
    chk("c100_ndone", dn_cnt - dn0, 1);
    chk("c100_nrej", rj_cnt - rj0, 0);

    for (int i = 0; i < 3; i++) begin
      snap();
      pulse(rej_x[i], rej_y[i]);
      repeat (3) @(negedge clk);
      chk("rej_nrej", rj_cnt - rj0, 1);
      chk("rej_ndone", dn_cnt - dn0, 1);
      chk("rej_npix", pv_cnt - pv0, 0);
      chk("rej_nren", rn_cnt - rn0, 0);
    end

    pulse(3, 3);
    repeat (20) @(negedge clk);
    chk("c3_idx1", captured[1], 3);
    chk("c3_idx13", captured[13], 6);
    pulse(196, 196);
    repeat (20) @(negedge clk);
    chk("c196_idx5", captured[5], 79);

    snap();
    pulse(100, 100);
    repeat (4) @(negedge clk);
    pulse(50, 50);
    repeat (18) @(negedge clk);
    chk("ign_idx0", captured[0], 44);
    chk("ign_idx13", captured[13], 41);
    chk("ign_npix", pv_cnt - pv0, 17);
    chk("ign_ndone", dn_cnt - dn0, 1);

    pulse(100, 100);
    repeat (7) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ren", int'(ram_ren), 0);
    chk("midrst_valid", int'(pix_valid), 0);
    chk("midrst_yaddr", int'(ram_y_addr), 0);
    snap();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_npix", pv_cnt - pv0, 0);
    chk("midrst_ndone", dn_cnt - dn0, 0);

    snap();
    pulse(60, 60);
    repeat (20) @(negedge clk);
    chk("c60_idx0", captured[0], 180);
    chk("c60_npix", pv_cnt - pv0, 17);
    chk("c60_ndone", dn_cnt - dn0, 1);

    snap();
    pulse(80, 40);
    repeat (17) @(negedge clk);
    cx = XW'(120);
    cy = YW'(30);
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    repeat (22) @(negedge clk);
    chk("b2b_npix", pv_cnt - pv0, 34);
    chk("b2b_ndone", dn_cnt - dn0, 2);
    chk("b2b_nren", rn_cnt - rn0, 34);
    chk("b2b_idx0", captured[0], pix(120, 30));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
